if_fetch_stage: RTL

//  Dual-issue instruction fetch stage that feeds ID_stage. Each cycle it drives two word addresses
//  (PC, PC+4) to the synchronous instruction ROM and presents the returned pair to ID as

---
 rtl/if_fetch_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Dual-issue instruction fetch stage feeding ID. Each cycle the stage drives
// two word addresses (pc, pc+4) to a synchronous instruction ROM. One cycle
// later it presents the returned pair to ID as inst_1/inst_2, tagged with
// PC1/PC2 (fetch address + 4 / + 8).
//
// Redirects:
//   - EX redirects on a taken branch or jump.
//   - ID redirects on partial-issue rollback.
//   - EX has priority over ID.
//   - Targets are forced word-aligned.
//   - The pair in flight at the redirect edge is squashed into a nop pair.
//
// Optional feature (macro IF_HANG_EN):
//   - Adds the pipeline_hang input.
//   - While hang is high (and there is no redirect), pc/fpc/squash hold.
//   - The last presented output pair is replayed from shadow registers.
//
// Parameters:
//   RESET_PC    fetch address loaded on reset
//   IMEM_WORDS  ROM depth in words; fetches at or beyond it return nop
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   ID_set_PC, ID_PC    ID redirect request / target
//   EX_set_PC, EX_PC    EX redirect request / target (wins over ID)
//   IAddr1, IAddr2      ROM byte addresses (pc, pc+4)
//   IData1, IData2      ROM data, valid the cycle after the address
//   PC1, PC2            address of inst_1 + 4 / + 8
//   inst_1, inst_2      instructions to ID, 32'h0 = bubble
//   pipeline_hang       stall request (IF_HANG_EN only)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
`ifdef IF_HANG_EN
  input  logic        pipeline_hang,
`endif
  input  logic        CLK,
  input  logic        RST,
  input  logic        ID_set_PC,
  input  logic [31:0] ID_PC,
  input  logic        EX_set_PC,
  input  logic [31:0] EX_PC,
  output logic [31:0] IAddr1,
  output logic [31:0] IAddr2,
  input  logic [31:0] IData1,
  input  logic [31:0] IData2,
  output logic [31:0] PC1,
  output logic [31:0] PC2,
  output logic [31:0] inst_1,
  output logic [31:0] inst_2
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);
  localparam logic [31:0] NOP        = 32'h0000_0000;

  // Fetch state
  logic [31:0] pc_reg, pc_next;
  logic [31:0] fpc_reg, fpc_next;
  logic        squash_reg, squash_next;

  // Redirect decode
  logic        redirect;
  logic [31:0] redirect_target;

  // Live (unstalled) view of the output pair
  logic [31:0] word1_idx, word2_idx;
  logic        word1_oob, word2_oob;
  logic [31:0] live_pc1, live_pc2, live_inst1, live_inst2;

  // ---------------------------------------------------------------------------
  // ROM addresses come straight from pc; 32-bit wraparound is intended.
  // ---------------------------------------------------------------------------
  assign IAddr1 = pc_reg;
  assign IAddr2 = pc_reg + 32'd4;

  // EX outranks ID when both redirect in the same cycle.
  assign redirect        = EX_set_PC | ID_set_PC;
  assign redirect_target = EX_set_PC ? {EX_PC[31:2], 2'b00}
                                     : {ID_PC[31:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_next     = pc_reg + 32'd8;
    fpc_next    = pc_reg;
    squash_next = 1'b0;
    if (redirect) begin
      // The pair addressed this cycle is wrong-path; mark it for squashing.
      pc_next     = redirect_target;
      squash_next = 1'b1;
`ifdef IF_HANG_EN
    end else if (pipeline_hang) begin
      pc_next     = pc_reg;
      fpc_next    = fpc_reg;
      squash_next = squash_reg;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg     <= RESET_PC;
      fpc_reg    <= 32'h0000_0000;
      squash_reg <= 1'b1;
    end else begin
      pc_reg     <= pc_next;
      fpc_reg    <= fpc_next;
      squash_reg <= squash_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output pair formation.
  // A fetch at or beyond the ROM depth reads as nop. The word index is at
  // most 2^30-1, so the +1 for the second slot cannot overflow 32 bits.
  // ---------------------------------------------------------------------------
  assign word1_idx = {2'b00, fpc_reg[31:2]};
  assign word2_idx = word1_idx + 32'd1;
  assign word1_oob = (word1_idx >= IMEM_LIMIT);
  assign word2_oob = (word2_idx >= IMEM_LIMIT);

  assign live_pc1   = fpc_reg + 32'd4;
  assign live_pc2   = fpc_reg + 32'd8;
  assign live_inst1 = (squash_reg || word1_oob) ? NOP : IData1;
  assign live_inst2 = (squash_reg || word2_oob) ? NOP : IData2;

`ifdef IF_HANG_EN
  // ---------------------------------------------------------------------------
  // Hang shadow.
  // While pc is held, the ROM is already returning the *next* pair. So the
  // pair ID is stalled on has to come from these registers, not from IData.
  // It is captured on the first hang edge and kept for the rest of the hang.
  // ---------------------------------------------------------------------------
  logic        hold_reg;
  logic [31:0] shadow_pc1_reg, shadow_pc2_reg;
  logic [31:0] shadow_inst1_reg, shadow_inst2_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_reg         <= 1'b0;
      shadow_pc1_reg   <= 32'h0;
      shadow_pc2_reg   <= 32'h0;
      shadow_inst1_reg <= 32'h0;
      shadow_inst2_reg <= 32'h0;
    end else if (redirect) begin
      hold_reg <= 1'b0;
    end else if (pipeline_hang) begin
      hold_reg <= 1'b1;
      if (!hold_reg) begin
        shadow_pc1_reg   <= live_pc1;
        shadow_pc2_reg   <= live_pc2;
        shadow_inst1_reg <= live_inst1;
        shadow_inst2_reg <= live_inst2;
      end
    end else begin
      hold_reg <= 1'b0;
    end
  end

  assign PC1    = hold_reg ? shadow_pc1_reg   : live_pc1;
  assign PC2    = hold_reg ? shadow_pc2_reg   : live_pc2;
  assign inst_1 = hold_reg ? shadow_inst1_reg : live_inst1;
  assign inst_2 = hold_reg ? shadow_inst2_reg : live_inst2;
`else
  assign PC1    = live_pc1;
  assign PC2    = live_pc2;
  assign inst_1 = live_inst1;
  assign inst_2 = live_inst2;
`endif

endmodule
